thresh_ramp_ctrl: RTL and testbench

//  Owns the logic-analyzer input thresholds and drives the 8-bit VIH/VIL duty

---
 rtl/thresh_ramp_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_thresh_ramp_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/thresh_ramp_ctrl.sv
// thresh_ramp_ctrl: owns the logic-analyzer VIH/VIL threshold duty words.
// Writes retarget the thresholds. The duty words move to the targets without
// the high word ever dropping below low word + MIN_GAP. thr_rdy rises once
// both words sit at target and the settle time has elapsed.
// Build option THR_RAMP_EN: defined  -> duty words slew in STEP-sized ticks.
//                           undefined -> a valid write copies the target
//                                        into the duty word at once.
module thresh_ramp_ctrl #(
    parameter int unsigned STEP          = 4,
    parameter int unsigned STEP_CYCLES   = 256,
    parameter int unsigned SETTLE_CYCLES = 65536,
    parameter int unsigned MIN_GAP       = 8,
    parameter logic [7:0]  VIH_RST       = 8'hC0,
    parameter logic [7:0]  VIL_RST       = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       thr_wr,
    input  logic       thr_sel,
    input  logic [7:0] thr_data,
    output logic [7:0] VIH,
    output logic [7:0] VIL,
    output logic       thr_rdy,
    output logic       thr_err
);

    localparam int unsigned DW       = 8;
    localparam int unsigned MW       = DW + 1;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [MW-1:0] GAP9   = MW'(MIN_GAP);

    // Reject a parameter set that cannot hold the gap invariant out of reset
    if (STEP < 1 || STEP > 255 || STEP_CYCLES < 1 || SETTLE_CYCLES < 1 ||
        int'(VIH_RST) < int'(VIL_RST) + int'(MIN_GAP)) begin : g_param_check
        $error("thresh_ramp_ctrl: illegal parameter set");
    end

`ifdef THR_RAMP_EN
    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_READY  = 2'd1,
        ST_RAMP   = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_READY  = 2'd1
    } state_e;
`endif

    state_e               state_q;
    logic [DW-1:0]        vih_q;
    logic [DW-1:0]        vil_q;
    logic [DW-1:0]        tgt_h_q;
    logic [DW-1:0]        tgt_l_q;
    logic [SETTLE_W-1:0]  settle_cnt_q;
    logic                 rdy_q;
    logic                 err_q;
    logic                 wr_ok;
    logic [MW-1:0]        data9;
    logic [MW-1:0]        tgt_h9;
    logic [MW-1:0]        tgt_l9;

    // Validate a write against the other channel's target in 9-bit math
    always_comb begin
        data9  = MW'(thr_data);
        tgt_h9 = MW'(tgt_h_q);
        tgt_l9 = MW'(tgt_l_q);
        if (thr_sel) begin
            wr_ok = (data9 >= tgt_l9 + GAP9);
        end else begin
            wr_ok = (tgt_h9 >= data9 + GAP9);
        end
    end

`ifdef THR_RAMP_EN
    logic [STEP_W-1:0] step_cnt_q;
    logic [DW-1:0]     vih_d;
    logic [DW-1:0]     vil_d;
    logic [MW-1:0]     nh;
    logic [MW-1:0]     nl;
    logic              step_tick;

    // One bounded move of x toward t; lands on t when within STEP
    function automatic logic [MW-1:0] step_toward(input logic [MW-1:0] x,
                                                  input logic [MW-1:0] t);
        logic [MW-1:0] r;
        if (t >= x) begin
            r = ((t - x) <= MW'(STEP)) ? t : x + MW'(STEP);
        end else begin
            r = ((x - t) <= MW'(STEP)) ? t : x - MW'(STEP);
        end
        return r;
    endfunction

    // Next duties on a tick: VIH first (floored above current VIL), then VIL under the new VIH
    always_comb begin
        step_tick = (step_cnt_q == STEP_W'(STEP_CYCLES - 1));
        nh = step_toward(MW'(vih_q), tgt_h9);
        if (nh < MW'(vil_q) + GAP9) begin
            nh = MW'(vil_q) + GAP9;
        end
        nl = step_toward(MW'(vil_q), tgt_l9);
        if (nl > nh - GAP9) begin
            nl = nh - GAP9;
        end
        vih_d = DW'(nh);
        vil_d = DW'(nl);
    end
`endif

    // Control FSM, targets, duty words and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SETTLE;
            vih_q        <= VIH_RST;
            vil_q        <= VIL_RST;
            tgt_h_q      <= VIH_RST;
            tgt_l_q      <= VIL_RST;
            settle_cnt_q <= '0;
            rdy_q        <= 1'b0;
            err_q        <= 1'b0;
`ifdef THR_RAMP_EN
            step_cnt_q   <= '0;
`endif
        end else begin
            err_q <= thr_wr & ~wr_ok;
            if (thr_wr && wr_ok) begin
                if (thr_sel) begin
                    tgt_h_q <= thr_data;
                end else begin
                    tgt_l_q <= thr_data;
                end
                rdy_q <= 1'b0;
`ifdef THR_RAMP_EN
                state_q    <= ST_RAMP;
                step_cnt_q <= '0;
`else
                if (thr_sel) begin
                    vih_q <= thr_data;
                end else begin
                    vil_q <= thr_data;
                end
                state_q      <= ST_SETTLE;
                settle_cnt_q <= '0;
`endif
            end else begin
                case (state_q)
`ifdef THR_RAMP_EN
                    ST_RAMP: begin
                        if (step_tick) begin
                            step_cnt_q <= '0;
                            vih_q      <= vih_d;
                            vil_q      <= vil_d;
                            if (vih_d == tgt_h_q && vil_d == tgt_l_q) begin
                                state_q      <= ST_SETTLE;
                                settle_cnt_q <= '0;
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + STEP_W'(1);
                        end
                    end
`endif
                    ST_SETTLE: begin
                        if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                            state_q <= ST_READY;
                            rdy_q   <= 1'b1;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SETTLE_W'(1);
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign VIH     = vih_q;
    assign VIL     = vil_q;
    assign thr_rdy = rdy_q;
    assign thr_err = err_q;

endmodule

// File: tb/tb_thresh_ramp_ctrl.sv
// Bench for thresh_ramp_ctrl: directed threshold scenarios plus random writes,
// every cycle compared against a behavioural model of the threshold rules.
module tb_thresh_ramp_ctrl;

    localparam int STEP  = 4;
    localparam int SC    = 4;
    localparam int SETC  = 8;
    localparam int GAP   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       thr_wr = 1'b0;
    logic       thr_sel = 1'b0;
    logic [7:0] thr_data = 8'h00;
    logic [7:0] VIH;
    logic [7:0] VIL;
    logic       thr_rdy;
    logic       thr_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: duties, targets, settle countdown, ramp progress
    int m_h, m_l, t_h, t_l, left, tick;
    bit m_rdy, m_err, ramping;

    thresh_ramp_ctrl #(
        .STEP(STEP), .STEP_CYCLES(SC), .SETTLE_CYCLES(SETC), .MIN_GAP(GAP),
        .VIH_RST(8'hC0), .VIL_RST(8'h40)
    ) dut (
        .clk(clk), .rst(rst), .thr_wr(thr_wr), .thr_sel(thr_sel),
        .thr_data(thr_data), .VIH(VIH), .VIL(VIL),
        .thr_rdy(thr_rdy), .thr_err(thr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int toward(int x, int t);
        if (t > x + STEP) return x + STEP;
        if (t < x - STEP) return x - STEP;
        return t;
    endfunction

    task automatic model_reset();
        m_h = 'hC0; m_l = 'h40; t_h = 'hC0; t_l = 'h40;
        left = SETC; m_rdy = 0; m_err = 0; ramping = 0; tick = 0;
    endtask

    task automatic model_edge(input bit wr, input bit sel, input int d);
        bit ok;
        int nh, nl;
        ok = 0;
        m_err = 0;
        if (wr) begin
            ok = sel ? (d >= t_l + GAP) : (t_h >= d + GAP);
            m_err = !ok;
        end
        if (ok) begin
            if (sel) t_h = d; else t_l = d;
            m_rdy = 0;
`ifdef THR_RAMP_EN
            ramping = 1;
            tick = 0;
`else
            m_h = t_h;
            m_l = t_l;
            left = SETC;
`endif
        end else if (ramping) begin
            if (tick == SC - 1) begin
                tick = 0;
                nh = toward(m_h, t_h);
                if (nh < m_l + GAP) nh = m_l + GAP;
                nl = toward(m_l, t_l);
                if (nl > nh - GAP) nl = nh - GAP;
                m_h = nh;
                m_l = nl;
                if (m_h == t_h && m_l == t_l) begin
                    ramping = 0;
                    left = SETC;
                end
            end else begin
                tick++;
            end
        end else if (left > 0) begin
            left--;
            if (left == 0) m_rdy = 1;
        end
    endtask

    // Step the model on each rising edge, compare on the falling edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_edge(thr_wr, thr_sel, int'(thr_data));
            @(negedge clk);
            if (rst) model_reset();
            chk("vih", 32'(VIH), 32'(m_h));
            chk("vil", 32'(VIL), 32'(m_l));
            chk("rdy", 32'(thr_rdy), 32'(m_rdy));
            chk("err", 32'(thr_err), 32'(m_err));
            chk("gap", 32'(int'(VIH) >= int'(VIL) + GAP), 32'd1);
        end
    end

    task automatic wr(input bit sel, input logic [7:0] d);
        thr_wr = 1'b1;
        thr_sel = sel;
        thr_data = d;
        @(negedge clk);
        thr_wr = 1'b0;
    endtask

    task automatic check_settle_from_now(input string tag);
        repeat (7) @(negedge clk);
        chk({tag, "_rdy_lo"}, 32'(thr_rdy), 32'd0);
        @(negedge clk);
        chk({tag, "_rdy_hi"}, 32'(thr_rdy), 32'd1);
    endtask

    initial begin
        int n;
        int nw;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_vih", 32'(VIH), 32'hC0);
        chk("rst_vil", 32'(VIL), 32'h40);
        chk("rst_rdy", 32'(thr_rdy), 32'd0);
        check_settle_from_now("rel");
        chk("rel_err", 32'(thr_err), 32'd0);

`ifdef THR_RAMP_EN
        wr(1'b1, 8'hD0);
        chk("ramp_rdy_drop", 32'(thr_rdy), 32'd0);
        repeat (3) @(negedge clk);
        chk("ramp_hold", 32'(VIH), 32'hC0);
        @(negedge clk);
        chk("ramp_c4", 32'(VIH), 32'hC4);
        repeat (12) @(negedge clk);
        chk("ramp_d0", 32'(VIH), 32'hD0);
        check_settle_from_now("ramp");
        wr(1'b0, 8'hCC);
        chk("bad_vil_err", 32'(thr_err), 32'd1);
        chk("bad_vil_keep", 32'(VIL), 32'h40);
        chk("bad_vil_rdy", 32'(thr_rdy), 32'd1);
        @(negedge clk);
        chk("bad_vil_pulse", 32'(thr_err), 32'd0);
`else
        wr(1'b1, 8'hF0);
        chk("cp_vih", 32'(VIH), 32'hF0);
        chk("cp_rdy_drop", 32'(thr_rdy), 32'd0);
        check_settle_from_now("cp");
        wr(1'b0, 8'hEC);
        chk("bad_vil_err", 32'(thr_err), 32'd1);
        chk("bad_vil_keep", 32'(VIL), 32'h40);
        chk("bad_vil_rdy", 32'(thr_rdy), 32'd1);
        @(negedge clk);
        chk("bad_vil_pulse", 32'(thr_err), 32'd0);
        wr(1'b0, 8'hE8);
        chk("edge_vil_ok", 32'(VIL), 32'hE8);
        chk("edge_vil_noerr", 32'(thr_err), 32'd0);
        wr(1'b1, 8'hEF);
        chk("edge_vih_err", 32'(thr_err), 32'd1);
        chk("edge_vih_keep", 32'(VIH), 32'hF0);
`endif

        wr(1'b1, 8'hE0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_vih", 32'(VIH), 32'hC0);
        chk("arst_vil", 32'(VIL), 32'h40);
        chk("arst_rdy", 32'(thr_rdy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_settle_from_now("arst");

        for (int b = 0; b < 60; b++) begin
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++) begin
                wr(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            repeat ($urandom_range(5, 40)) @(negedge clk);
        end

        n = 0;
        while (!thr_rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("final_rdy", 32'(thr_rdy), 32'd1);
        chk("final_vih", 32'(VIH), 32'(t_h));
        chk("final_vil", 32'(VIL), 32'(t_l));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
